// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, timer register map and bus-response state type.
// AHB_TIMER_PRESCALER_EN adds the PRESCALE register to the map.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_LOAD     = 8'h04;
  localparam logic [7:0] OFF_VALUE    = 8'h08;
  localparam logic [7:0] OFF_INTSTAT  = 8'h0C;
  localparam logic [7:0] OFF_PRESCALE = 8'h10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQEN   = 1;
  localparam int CTRL_ONESHOT = 2;

`ifdef AHB_TIMER_PRESCALER_EN
  localparam int NUM_REGS = 5;
`else
  localparam int NUM_REGS = 4;
`endif

  // Register selector carries the word index of each register.
  typedef enum logic [2:0] {
    REG_CTRL     = 3'(OFF_CTRL     >> 2),
    REG_LOAD     = 3'(OFF_LOAD     >> 2),
    REG_VALUE    = 3'(OFF_VALUE    >> 2),
    REG_INTSTAT  = 3'(OFF_INTSTAT  >> 2),
    REG_PRESCALE = 3'(OFF_PRESCALE >> 2)
  } reg_e;

  typedef enum logic [1:0] {OKAY, ERR1, ERR2} resp_st_e;

endpackage

// File: rtl/ahb_lite_timer_if.sv
// AHB-Lite slave-side bus bundle for the timer peripheral.
interface ahb_lite_timer_if #(parameter int ADDR_WIDTH = 12);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic [31:0]           HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                  input  HRDATA, HREADYOUT, HRESP);
  modport slave  (input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/ahb_lite_slave_if.sv
// AHB-Lite transfer acceptance, data-phase registration, legality check and
// two-cycle ERROR response FSM. Map size follows AHB_TIMER_PRESCALER_EN.
module ahb_lite_slave_if
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic                  hready,
  output logic                  wr_en,
  output logic                  rd_en,
  output reg_e                  reg_sel,
  output logic                  hreadyout,
  output logic                  hresp
);
  logic                  accept, legal;
  logic [ADDR_WIDTH-3:0] word;
  logic                  dp_vld, dp_wr;
  resp_st_e              st, st_nxt;

  assign word   = haddr[ADDR_WIDTH-1:2];
  assign accept = hsel && hready && htrans[1];
  assign legal  = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00) &&
                  (word < (ADDR_WIDTH-2)'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vld  <= 1'b0;
      dp_wr   <= 1'b0;
      reg_sel <= REG_CTRL;
      st      <= OKAY;
    end else begin
      dp_vld  <= accept && legal;
      dp_wr   <= hwrite;
      reg_sel <= reg_e'(word[2:0]);
      st      <= st_nxt;
    end
  end

  always_comb begin
    st_nxt    = OKAY;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (st)
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        st_nxt    = ERR2;
      end
      // The final ERROR cycle completes with HREADY high, so a new illegal
      // transfer accepted here restarts the sequence back-to-back.
      ERR2: begin
        hresp = 1'b1;
        if (accept && !legal) st_nxt = ERR1;
      end
      default: if (accept && !legal) st_nxt = ERR1;
    endcase
  end

  assign wr_en = dp_vld && dp_wr;
  assign rd_en = dp_vld && !dp_wr;

endmodule

// File: rtl/ahb_lite_timer.sv
// AHB-Lite 32-bit auto-reload down-counter with level IRQ.
// AHB_TIMER_PRESCALER_EN adds an 8-bit PRESCALE register and tick divider.
module ahb_lite_timer
  import ahb_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_lite_timer_if.slave bus,
  output logic            TIMERINT
);
  logic        wr_en, rd_en;
  reg_e        reg_sel;
  logic        ctrl_en, ctrl_irqen, ctrl_oneshot, raw;
  logic [31:0] load_q, value_q;
  logic        tick, expire;
  logic        wr_ctrl, wr_load, wr_value, wr_intstat;

  ahb_lite_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_slv (
    .clk      (HCLK),
    .rst      (HRESET),
    .hsel     (bus.HSEL),
    .haddr    (bus.HADDR),
    .htrans   (bus.HTRANS),
    .hwrite   (bus.HWRITE),
    .hsize    (bus.HSIZE),
    .hready   (bus.HREADY),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .reg_sel  (reg_sel),
    .hreadyout(bus.HREADYOUT),
    .hresp    (bus.HRESP)
  );

  assign wr_ctrl    = wr_en && (reg_sel == REG_CTRL);
  assign wr_load    = wr_en && (reg_sel == REG_LOAD);
  assign wr_value   = wr_en && (reg_sel == REG_VALUE);
  assign wr_intstat = wr_en && (reg_sel == REG_INTSTAT);
  assign expire     = tick && (value_q == 32'd0);

`ifdef AHB_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, pre_cnt;
  logic       wr_prescale;

  assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);
  assign tick        = ctrl_en && (pre_cnt == prescale_q);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      prescale_q <= 8'd0;
      pre_cnt    <= 8'd0;
    end else begin
      if (wr_prescale) prescale_q <= bus.HWDATA[7:0];
      if (wr_prescale || !ctrl_en || tick) pre_cnt <= 8'd0;
      else                                 pre_cnt <= pre_cnt + 8'd1;
    end
  end
`else
  assign tick = ctrl_en;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_en      <= 1'b0;
      ctrl_irqen   <= 1'b0;
      ctrl_oneshot <= 1'b0;
      load_q       <= RESET_LOAD;
      value_q      <= RESET_LOAD;
      raw          <= 1'b0;
    end else begin
      // A bus write beats the counter; expiry still reloads and sets RAW
      // even when the same cycle's CTRL write clears EN.
      if (wr_ctrl) begin
        ctrl_en      <= bus.HWDATA[CTRL_EN];
        ctrl_irqen   <= bus.HWDATA[CTRL_IRQEN];
        ctrl_oneshot <= bus.HWDATA[CTRL_ONESHOT];
      end else if (expire && ctrl_oneshot) begin
        ctrl_en <= 1'b0;
      end
      if (wr_load) load_q <= bus.HWDATA;
      if (wr_value)    value_q <= bus.HWDATA;
      else if (expire) value_q <= load_q;
      else if (tick)   value_q <= value_q - 32'd1;
      if (expire)                              raw <= 1'b1;
      else if (wr_intstat && bus.HWDATA[0])    raw <= 1'b0;
    end
  end

  always_comb begin
    bus.HRDATA = 32'd0;
    if (rd_en) begin
      case (reg_sel)
        REG_CTRL:     bus.HRDATA = {29'd0, ctrl_oneshot, ctrl_irqen, ctrl_en};
        REG_LOAD:     bus.HRDATA = load_q;
        REG_VALUE:    bus.HRDATA = value_q;
        REG_INTSTAT:  bus.HRDATA = {31'd0, raw};
`ifdef AHB_TIMER_PRESCALER_EN
        REG_PRESCALE: bus.HRDATA = {24'd0, prescale_q};
`endif
        default:      bus.HRDATA = 32'd0;
      endcase
    end
  end

  assign TIMERINT = raw && ctrl_irqen;

endmodule
